// File: rtl/mem_uart_master_if.sv
// Bus bundle for mem_uart_master: the processor-side memory port together with
// the channel-0 message port of the UART multiplexer.
interface mem_uart_master_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_wdone;
    logic        mem_err;
    logic        msg_send_flag;
    logic [4:0]  msg_send_length;
    logic [71:0] msg_send_data;
    logic        msg_writable;
    logic        msg_recv_flag;
    logic [4:0]  msg_recv_length;
    logic [71:0] msg_recv_data;
    logic        msg_readable;

    modport master (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata, mem_wdone, mem_err,
        output msg_send_flag, msg_send_length, msg_send_data,
        input  msg_writable,
        output msg_recv_flag,
        input  msg_recv_length, msg_recv_data, msg_readable
    );

    modport slave (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata, mem_wdone, mem_err,
        input  msg_send_flag, msg_send_length, msg_send_data,
        output msg_writable,
        input  msg_recv_flag,
        output msg_recv_length, msg_recv_data, msg_readable
    );
endinterface

// File: rtl/mem_uart_master.sv
// Memory-bus to UART-message bridge (channel 0): posted writes, blocking reads.
// Optional read-response timeout enabled by defining MEM_UART_MASTER_TIMEOUT_EN.
module mem_uart_master #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              CLK,
    input  logic              RST,
    mem_uart_master_if.master bus
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

    state_t      r_state, w_state_nxt;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;

    logic        r_rvalid, w_rvalid;
    logic        r_wdone, w_wdone;
    logic        r_err, w_err;
    logic        r_send_flag, w_send_flag;
    logic        r_recv_flag, w_recv_flag;
    logic [31:0] r_rdata, w_rdata;
    logic [4:0]  r_send_len, w_send_len;
    logic [71:0] r_send_data, w_send_data;
    logic        w_latch;
    logic        w_rx_avail;
    logic        w_rx_good;

`ifdef MEM_UART_MASTER_TIMEOUT_EN
    logic [31:0] r_tmo_cnt, w_tmo_cnt_nxt;
`else
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // The pop flag is registered, so the message popped last edge is still
    // visible this cycle; ignore it to avoid consuming it twice.
    assign w_rx_avail = bus.msg_readable && !r_recv_flag;
    assign w_rx_good  = w_rx_avail && (bus.msg_recv_length == 5'd4);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_rvalid    = 1'b0;
        w_wdone     = 1'b0;
        w_err       = 1'b0;
        w_send_flag = 1'b0;
        w_recv_flag = 1'b0;
        w_rdata     = r_rdata;
        w_send_len  = r_send_len;
        w_send_data = r_send_data;
`ifdef MEM_UART_MASTER_TIMEOUT_EN
        w_tmo_cnt_nxt = r_tmo_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_rx_avail) begin
                    w_recv_flag = 1'b1;
                    w_err       = 1'b1;
                end
                if (bus.mem_req) begin
                    if (bus.mem_we && (bus.mem_wmask == 4'd0)) begin
                        w_wdone = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = SEND;
                    end
                end
            end
            SEND: begin
                if (bus.msg_writable) begin
                    w_send_flag = 1'b1;
                    if (r_we) begin
                        w_send_len  = 5'd9;
                        w_send_data = {4'h0, r_wmask, r_addr, r_wdata};
                        w_wdone     = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_send_len  = 5'd5;
                        w_send_data = {40'h0, r_addr};
                        w_state_nxt = WAIT_RSP;
`ifdef MEM_UART_MASTER_TIMEOUT_EN
                        w_tmo_cnt_nxt = 32'd0;
`endif
                    end
                end
            end
            WAIT_RSP: begin
                if (w_rx_avail) begin
                    w_recv_flag = 1'b1;
                    if (w_rx_good) begin
                        w_rdata     = bus.msg_recv_data[31:0];
                        w_rvalid    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_err = 1'b1;
                    end
                end
`ifdef MEM_UART_MASTER_TIMEOUT_EN
                if (!w_rx_good) begin
                    if (r_tmo_cnt >= TIMEOUT_CYCLES - 1) begin
                        w_rvalid    = 1'b1;
                        w_err       = 1'b1;
                        w_rdata     = 32'hDEADBEEF;
                        w_state_nxt = IDLE;
                    end else begin
                        w_tmo_cnt_nxt = r_tmo_cnt + 32'd1;
                    end
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rvalid    <= 1'b0;
            r_wdone     <= 1'b0;
            r_err       <= 1'b0;
            r_send_flag <= 1'b0;
            r_recv_flag <= 1'b0;
            r_rdata     <= 32'd0;
            r_send_len  <= 5'd0;
            r_send_data <= 72'd0;
        end else begin
            r_rvalid    <= w_rvalid;
            r_wdone     <= w_wdone;
            r_err       <= w_err;
            r_send_flag <= w_send_flag;
            r_recv_flag <= w_recv_flag;
            r_rdata     <= w_rdata;
            r_send_len  <= w_send_len;
            r_send_data <= w_send_data;
        end
    end

`ifdef MEM_UART_MASTER_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tmo_cnt <= 32'd0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end
`endif

    // Request fields are only consumed in SEND, so they need no reset.
    always_ff @(posedge CLK) begin
        if (w_latch) begin
            r_we    <= bus.mem_we;
            r_addr  <= bus.mem_addr;
            r_wdata <= bus.mem_wdata;
            r_wmask <= bus.mem_wmask;
        end
    end

    assign bus.mem_ready       = (r_state == IDLE);
    assign bus.mem_rvalid      = r_rvalid;
    assign bus.mem_rdata       = r_rdata;
    assign bus.mem_wdone       = r_wdone;
    assign bus.mem_err         = r_err;
    assign bus.msg_send_flag   = r_send_flag;
    assign bus.msg_send_length = r_send_len;
    assign bus.msg_send_data   = r_send_data;
    assign bus.msg_recv_flag   = r_recv_flag;

endmodule

// File: tb/tb_mem_uart_master.sv
// Randomized bench for mem_uart_master: the bench plays processor, multiplexer
// and a word-addressed memory model that answers read requests.
module tb_mem_uart_master;

    localparam int unsigned TMO = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [31:0] last_rdata;
    logic [31:0] mem_m [logic [31:0]];

    mem_uart_master_if bus ();

    mem_uart_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] mask);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = nw[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return 32'd0;
    endfunction

    task automatic put_rsp(input logic [4:0] len, input logic [71:0] data);
        bus.msg_readable    = 1'b1;
        bus.msg_recv_length = len;
        bus.msg_recv_data   = data;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            input int wdelay);
        chk("wr_ready", bus.mem_ready, 1);
        bus.mem_req = 1'b1; bus.mem_we = 1'b1;
        bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wmask = m;
        bus.msg_writable = (wdelay == 0);
        tick();
        bus.mem_req = 1'b0;
        if (m == 4'd0) begin
            chk("wr0_done", bus.mem_wdone, 1);
            chk("wr0_nopush", bus.msg_send_flag, 0);
            chk("wr0_ready", bus.mem_ready, 1);
            bus.msg_writable = 1'b1;
            tick();
            chk("wr0_pulse", bus.mem_wdone, 0);
            chk("wr0_nopush2", bus.msg_send_flag, 0);
        end else begin
            for (int i = 0; i < wdelay; i++) begin
                tick();
                chk("wr_nopush", bus.msg_send_flag, 0);
                chk("wr_busy", bus.mem_ready, 0);
            end
            bus.msg_writable = 1'b1;
            tick();
            chk("wr_push", bus.msg_send_flag, 1);
            chk("wr_done", bus.mem_wdone, 1);
            chk("wr_len", bus.msg_send_length, 9);
            chk("wr_msg", bus.msg_send_data, {4'h0, m, a, d});
            chk("wr_idle", bus.mem_ready, 1);
            tick();
            chk("wr_push_pulse", bus.msg_send_flag, 0);
            chk("wr_done_pulse", bus.mem_wdone, 0);
            chk("wr_len_hold", bus.msg_send_length, 9);
            mem_m[a] = merge(mem_read(a), d, m);
        end
    endtask

    task automatic start_read(input logic [31:0] a, input int wdelay);
        chk("rd_ready", bus.mem_ready, 1);
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = a;
        bus.mem_wdata = $urandom; bus.mem_wmask = 4'($urandom_range(0, 15));
        bus.msg_writable = (wdelay == 0);
        tick();
        bus.mem_req = 1'b0;
        for (int i = 0; i < wdelay; i++) begin
            tick();
            chk("rd_nopush", bus.msg_send_flag, 0);
            chk("rd_busy", bus.mem_ready, 0);
        end
        bus.msg_writable = 1'b1;
        tick();
        chk("rd_push", bus.msg_send_flag, 1);
        chk("rd_len", bus.msg_send_length, 5);
        chk("rd_msg", bus.msg_send_data, {40'h0, a});
        chk("rd_wdone", bus.mem_wdone, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input int wdelay, input int rdelay, input bit bad);
        logic [31:0] rsp;
        rsp = mem_read(a);
        start_read(a, wdelay);
        for (int i = 0; i < rdelay; i++) begin
            tick();
            chk("rd_wait", bus.mem_ready, 0);
            chk("rd_wait_push", bus.msg_send_flag, 0);
        end
        if (bad) begin
            put_rsp(5'd9, {$urandom, $urandom, 8'($urandom)});
            tick();
            chk("bad_pop", bus.msg_recv_flag, 1);
            chk("bad_err", bus.mem_err, 1);
            chk("bad_nvalid", bus.mem_rvalid, 0);
            tick();
            chk("bad_once", bus.msg_recv_flag, 0);
            chk("bad_err_pulse", bus.mem_err, 0);
            chk("bad_wait", bus.mem_ready, 0);
        end
        put_rsp(5'd4, {40'($urandom), rsp});
        tick();
        chk("rd_pop", bus.msg_recv_flag, 1);
        chk("rd_valid", bus.mem_rvalid, 1);
        chk("rd_data", bus.mem_rdata, rsp);
        chk("rd_noerr", bus.mem_err, 0);
        chk("rd_idle", bus.mem_ready, 1);
        tick();
        bus.msg_readable = 1'b0;
        chk("rd_once", bus.msg_recv_flag, 0);
        chk("rd_pulse", bus.mem_rvalid, 0);
        chk("rd_hold", bus.mem_rdata, rsp);
        last_rdata = rsp;
    endtask

    task automatic stray();
        put_rsp(5'd4, {$urandom, $urandom, 8'($urandom)});
        tick();
        chk("stray_pop", bus.msg_recv_flag, 1);
        chk("stray_err", bus.mem_err, 1);
        chk("stray_nvalid", bus.mem_rvalid, 0);
        tick();
        bus.msg_readable = 1'b0;
        chk("stray_once", bus.msg_recv_flag, 0);
        chk("stray_err_pulse", bus.mem_err, 0);
        chk("stray_keep", bus.mem_rdata, last_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        n_cmp = 0; n_err = 0; last_rdata = 32'd0;
        rst_n = 1'b0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = 32'd0;
        bus.mem_wdata = 32'd0; bus.mem_wmask = 4'd0;
        bus.msg_writable = 1'b1; bus.msg_readable = 1'b0;
        bus.msg_recv_length = 5'd0; bus.msg_recv_data = 72'd0;
        tick(); tick();
        chk("rst_ready", bus.mem_ready, 1);
        chk("rst_rvalid", bus.mem_rvalid, 0);
        chk("rst_rdata", bus.mem_rdata, 0);
        chk("rst_send", bus.msg_send_flag, 0);
        chk("rst_len", bus.msg_send_length, 0);
        chk("rst_data", bus.msg_send_data, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Directed cases from the block's usage examples.
        mem_m[32'h10] = 32'h11223344;
        do_read(32'h10, 0, 0, 1'b0);
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, 0);
        do_write(32'h24, 32'h12345678, 4'b0000, 0);
        mem_m[32'h30] = 32'h00000005;
        do_read(32'h30, 10, 0, 1'b0);
        do_read(32'h30, 0, 2, 1'b1);
        stray();

        // Reset while waiting for a read response; the late reply is stray.
        start_read(32'h44, 0);
        tick();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_ready", bus.mem_ready, 1);
        chk("mid_rst_rvalid", bus.mem_rvalid, 0);
        chk("mid_rst_err", bus.mem_err, 0);
        chk("mid_rst_send", bus.msg_send_flag, 0);
        chk("mid_rst_recv", bus.msg_recv_flag, 0);
        chk("mid_rst_rdata", bus.mem_rdata, 0);
        chk("mid_rst_len", bus.msg_send_length, 0);
        chk("mid_rst_data", bus.msg_send_data, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        last_rdata = 32'd0;
        stray();

`ifdef MEM_UART_MASTER_TIMEOUT_EN
        start_read(32'h50, 0);
        for (int i = 0; i < int'(TMO) - 1; i++) begin
            tick();
            chk("tmo_wait", bus.mem_rvalid, 0);
        end
        tick();
        chk("tmo_valid", bus.mem_rvalid, 1);
        chk("tmo_err", bus.mem_err, 1);
        chk("tmo_data", bus.mem_rdata, 32'hDEADBEEF);
        chk("tmo_idle", bus.mem_ready, 1);
        tick();
        last_rdata = 32'hDEADBEEF;
        stray();
`endif

        for (int it = 0; it < 60; it++) begin
            a = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom,
                         ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                         $urandom_range(0, 3));
            end else begin
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 4),
                        ($urandom_range(0, 3) == 0));
            end
            if ($urandom_range(0, 7) == 0) stray();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_uart_master.md
# mem_uart_master

Processor-side bridge that converts single 32-bit memory bus accesses into request messages for channel 0 of the UART message multiplexer, and returns read data from the memory-model response messages. It sits directly upstream of the UART-attached simulation memory: its messages travel over `multchan_comm`/`uart_comm` and are consumed there. Reads block until a response arrives. Writes are posted: they complete once the message is handed to the multiplexer.

## Interface
- `TIMEOUT_CYCLES`, 65535: read-response wait limit, in cycles; used only with the timeout feature; must be ≥ 1.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `mem_req` in 1: access request, sampled when `mem_ready`=1.
- `mem_we` in 1: 1 = write, 0 = read.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data, little-endian.
- `mem_wmask` in 4: byte enables; bit i enables `mem_wdata[8i+7:8i]`.
- `mem_ready` out 1: bridge idle, request accepted this cycle.
- `mem_rvalid` out 1: one-cycle pulse, `mem_rdata` valid.
- `mem_rdata` out 32: read data, held until the next read completes.
- `mem_wdone` out 1: one-cycle pulse, write completed.
- `mem_err` out 1: one-cycle pulse, malformed response or timeout.
- `msg_send_flag` out 1: one-cycle push of a message to the multiplexer.
- `msg_send_length` out 5: request length in bytes.
- `msg_send_data` out 72: request payload.
- `msg_writable` in 1: multiplexer can accept a message.
- `msg_recv_flag` out 1: one-cycle pop of the received message.
- `msg_recv_length` in 5: received message length.
- `msg_recv_data` in 72: received payload.
- `msg_readable` in 1: a received message is pending.

## Operation
- States: IDLE, SEND, WAIT_RSP. `mem_ready` = (state==IDLE), combinational.
- **IDLE**
  - `mem_req`=1: latch we/addr/wdata/wmask, then go to SEND.
  - Exception: a write with `mem_wmask`=0 sends nothing; `mem_wdone` pulses next cycle and the state stays IDLE.
  - Any `msg_readable` in IDLE: pop it, pulse `mem_err` (stray response).
- **SEND**, when `msg_writable`=1, push exactly one message:
  - Read: length 5; data[31:0]=addr; data[71:32]=0.
  - Write: length 9; data[31:0]=wdata; [63:32]=addr; [67:64]=wmask; [71:68]=0.
  - After a read push, go to WAIT_RSP.
  - After a write push, go to IDLE with `mem_wdone` pulsing alongside `msg_send_flag`.
  - While `msg_writable`=0, hold in SEND indefinitely.
- **WAIT_RSP**, when `msg_readable`=1, pop the message:
  - Length 4: `mem_rdata`=data[31:0], pulse `mem_rvalid`, go to IDLE.
  - Any other length: pulse `mem_err`, discard, stay in WAIT_RSP.
- **Reset** (any state, including mid-transaction): IDLE; all pulse outputs 0; `mem_rdata`=0; `msg_send_length`=0; `msg_send_data`=0. A response to an aborted read arriving after reset is treated as stray.

## Timing
- All outputs except `mem_ready` are registered.
- Request accepted at edge N. SEND is evaluated at edge N+1; with `msg_writable`=1 there, `msg_send_flag` is high during cycle N+1..N+2.
- Write latency: `mem_wdone` 1 cycle after acceptance when `msg_writable` is already high.
- Read latency: `msg_recv_flag` and `mem_rvalid` assert in the same cycle, one edge after `msg_readable` is seen in WAIT_RSP.
- Next request accepted no earlier than the cycle after `mem_wdone`/`mem_rvalid`.
- `msg_send_data`/`msg_send_length` hold their last value between pushes.

## Configuration
- `MEM_UART_MASTER_TIMEOUT_EN`
  - Defined: a counter clears on entry to WAIT_RSP and increments each cycle without a valid response. On reaching `TIMEOUT_CYCLES`:
    - `mem_rvalid` and `mem_err` pulse together.
    - `mem_rdata`=32'hDEADBEEF.
    - State goes to IDLE.
    - A late response is then popped as stray.
  - Undefined: no counter; WAIT_RSP waits forever.

## Test plan
- Read 0x00000010, `msg_writable`=1 → push length 5, data=72'h00_0000_0000_0000_0010. Reply length 4 data 0x11223344 → `mem_rvalid` with `mem_rdata`=0x11223344, `msg_recv_flag` in the same cycle.
- Write addr 0x20, data 0xAABBCCDD, mask 4'b0101 → push length 9, data=72'h05_0000_0020_AABB_CCDD; `mem_wdone` pulses with the push.
- Write with mask 0 → no `msg_send_flag`; `mem_wdone` 1 cycle after acceptance.
- Hold `msg_writable`=0 for 10 cycles after a read request → no push and `mem_ready`=0 throughout; push on the first cycle after `msg_writable` rises.
- In WAIT_RSP, deliver a length-9 message, then a length-4 message with data 0x5 → `mem_err` pulse, then `mem_rvalid` with 0x5. Assert `RST`=0 mid-WAIT_RSP → IDLE, outputs at reset values.
- With `MEM_UART_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, no response → after 8 WAIT_RSP cycles, `mem_rvalid`+`mem_err` with 0xDEADBEEF. Late reply → popped, `mem_err` pulses.
